// File: rtl/mrr_pathway_packet_mux_pkg.sv
// Shared definitions for the MRR pathway packet mux: tag word layout and FSM encoding.
package mrr_pathway_packet_mux_pkg;

  localparam logic [7:0]  MrrTagMarker = 8'hA5;
  localparam int unsigned TagMarkerLsb = 24;
  localparam int unsigned TagPathLsb   = 16;
  localparam int unsigned TagSeqLsb    = 0;
  localparam int unsigned StateWidth   = 2;

  typedef enum logic [StateWidth-1:0] {
    StIdle,
    StTag,
    StData
  } state_e;

  // Reserved bits [23:20] stay zero.
  function automatic logic [31:0] mk_tag(input logic [3:0] grant, input logic [15:0] seq);
    logic [31:0] w;
    w                    = '0;
    w[TagMarkerLsb +: 8] = MrrTagMarker;
    w[TagPathLsb +: 4]   = grant;
    w[TagSeqLsb +: 16]   = seq;
    return w;
  endfunction

endpackage

// File: rtl/mrr_pathway_packet_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first request after last_i, wrapping modulo NumReq.
module mrr_pathway_packet_mux_rr_arbiter #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [3:0]        last_i,
  output logic [3:0]        grant_o,
  output logic              valid_o
);

  // Lowest index wins within each pass; the second pass (indices above last_i) overrides.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (req_i[i] && i <= int'(last_i)) begin
        grant_o = 4'(i);
        valid_o = 1'b1;
      end
    end
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (req_i[i] && i > int'(last_i)) begin
        grant_o = 4'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mrr_pathway_packet_mux.sv
// Merges per-pathway AXI-stream packets into one registered stream, packet-granular
// round-robin, with an optional tag word carrying pathway index and sequence number.
module mrr_pathway_packet_mux
  import mrr_pathway_packet_mux_pkg::*;
#(
  parameter int unsigned NUM_PATHWAYS = 4,
  parameter int unsigned SEQ_WIDTH    = 16,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [32*NUM_PATHWAYS-1:0] i_tdata,
  input  logic [NUM_PATHWAYS-1:0]    i_tlast,
  input  logic [NUM_PATHWAYS-1:0]    i_tkeep,
  input  logic [NUM_PATHWAYS-1:0]    i_tvalid,
  output logic [NUM_PATHWAYS-1:0]    i_tready,
  input  logic                       tag_enable,
  input  logic                       reset_diagnostic_counter,
  output logic [31:0]                o_tdata,
  output logic                       o_tlast,
  output logic                       o_tkeep,
  output logic                       o_tvalid,
  input  logic                       o_tready,
  output logic [CNT_WIDTH-1:0]       pkt_count,
  output logic [3:0]                 cur_grant
);

  state_e                state_q, state_d;
  logic [3:0]            cur_grant_q, cur_grant_d, last_grant_q, arb_grant;
  logic                  arb_valid, slot_free, load, load_last, load_keep, pkt_done;
  logic [31:0]           load_data, sel_data;
  logic                  sel_valid, sel_last, sel_keep;
  logic [SEQ_WIDTH-1:0]  sel_seq;
  logic [SEQ_WIDTH-1:0]  seq_q [NUM_PATHWAYS];
  logic [31:0]           tdata_q;
  logic                  tlast_q, tkeep_q, tvalid_q;
  logic [CNT_WIDTH-1:0]  pkt_count_q;

  mrr_pathway_packet_mux_rr_arbiter #(
    .NumReq (NUM_PATHWAYS)
  ) u_arb (
    .req_i   (i_tvalid),
    .last_i  (last_grant_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  assign slot_free = !tvalid_q || o_tready;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_keep  = 1'b0;
    sel_seq   = '0;
    for (int p = 0; p < int'(NUM_PATHWAYS); p++) begin
      if (cur_grant_q == 4'(p)) begin
        sel_data  = i_tdata[32*p +: 32];
        sel_valid = i_tvalid[p];
        sel_last  = i_tlast[p];
        sel_keep  = i_tkeep[p];
        sel_seq   = seq_q[p];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_grant_d = cur_grant_q;
    i_tready    = '0;
    load        = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    load_keep   = 1'b0;
    pkt_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          cur_grant_d = arb_grant;
          state_d     = tag_enable ? StTag : StData;
        end
      end
      StTag: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = mk_tag(cur_grant_q, 16'(sel_seq));
          load_keep = 1'b1;
          state_d   = StData;
        end
      end
      StData: begin
        for (int p = 0; p < int'(NUM_PATHWAYS); p++) begin
          if (cur_grant_q == 4'(p)) i_tready[p] = slot_free;
        end
        if (slot_free && sel_valid) begin
          load      = 1'b1;
          load_data = sel_data;
          load_last = sel_last;
          load_keep = sel_keep;
          if (sel_last) begin
            pkt_done = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cur_grant_q  <= '0;
      last_grant_q <= 4'(NUM_PATHWAYS - 1);
    end else begin
      state_q     <= state_d;
      cur_grant_q <= cur_grant_d;
      if (pkt_done) last_grant_q <= cur_grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tkeep_q  <= 1'b0;
    end else if (slot_free) begin
      tvalid_q <= load;
      if (load) begin
        tdata_q <= load_data;
        tlast_q <= load_last;
        tkeep_q <= load_keep;
      end
    end
  end

  // Diagnostic clear takes priority over a completing packet; seq counters are untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_q <= '0;
      for (int p = 0; p < int'(NUM_PATHWAYS); p++) seq_q[p] <= '0;
    end else begin
      if (reset_diagnostic_counter) pkt_count_q <= '0;
      else if (pkt_done)            pkt_count_q <= pkt_count_q + 1'b1;
      for (int p = 0; p < int'(NUM_PATHWAYS); p++) begin
        if (pkt_done && cur_grant_q == 4'(p)) seq_q[p] <= seq_q[p] + 1'b1;
      end
    end
  end

  assign o_tdata   = tdata_q;
  assign o_tlast   = tlast_q;
  assign o_tkeep   = tkeep_q;
  assign o_tvalid  = tvalid_q;
  assign pkt_count = pkt_count_q;
  assign cur_grant = cur_grant_q;

endmodule
